i2c_uart_bridge_ctrl: RTL
=========================

I2C_UART_BRIDGE_CTRL -- requirements
Module: i2c_uart_bridge_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, byte-queue depth (power of two, 2..64).
REQ-002 SHALL have parameter TERM_EN, default 1, which enables a terminator byte on each I2C STOP.
REQ-003 SHALL have parameter TERM_BYTE, default 8'h0A, the terminator value.
REQ-004 SHALL have port i_CLK  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_RST  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_rx_data  input  8  received I2C data byte, already synchronised to i_CLK.
REQ-007 SHALL have port i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
REQ-008 SHALL have port i_rx_stop  input  1  one-cycle strobe marking an I2C STOP.
REQ-009 SHALL have port i_tx_busy  input  1  UART transmitter busy.
REQ-010 SHALL have port i_clr_ovf  input  1  clears o_overflow.
REQ-011 SHALL have port o_tx_start  output  1  one-cycle UART send request.
REQ-012 SHALL have port o_tx_data  output  8  byte to transmit, held stable from o_tx_start until i_tx_busy falls.
REQ-013 SHALL have port o_level  output  clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-014 SHALL have port o_full  output  1  occupancy == FIFO_DEPTH.
REQ-015 SHALL have port o_overflow  output  1  sticky flag for a dropped byte.

Function
REQ-016 A byte with i_rx_valid=1 and o_full=0 SHALL be pushed at that edge.
REQ-017 A byte with i_rx_valid=1 and o_full=1 SHALL be dropped and SHALL set o_overflow.
REQ-018 o_overflow SHALL stay set until i_clr_ovf=1 or reset; a simultaneous set and clear SHALL leave it set.
REQ-019 With TERM_EN=1, i_rx_stop SHALL set a pending-terminator flag.
REQ-020 TERM_BYTE SHALL be pushed on the first edge with i_rx_valid=0, then the flag SHALL clear.
REQ-021 A second i_rx_stop while the terminator is pending SHALL NOT queue a second terminator.
REQ-022 A terminator that meets a full queue SHALL be dropped, SHALL set o_overflow and SHALL clear the flag.
REQ-023 A push and a pop on the same edge SHALL leave o_level unchanged, including when full.
REQ-024 The FSM states SHALL be IDLE, POP, START, WAIT_BUSY and WAIT_DONE.
REQ-025 IDLE SHALL go to POP when o_level!=0 and i_tx_busy=0; otherwise it SHALL stay in IDLE.
REQ-026 POP SHALL dequeue the head into the o_tx_data register and go to START.
REQ-027 START SHALL drive o_tx_start=1 for exactly one cycle and go to WAIT_BUSY.
REQ-028 WAIT_BUSY SHALL go to WAIT_DONE when i_tx_busy=1.
REQ-029 WAIT_BUSY SHALL re-pulse o_tx_start and restart its count when 16 cycles pass without i_tx_busy.
REQ-030 WAIT_DONE SHALL go to IDLE when i_tx_busy=0.
REQ-031 With an idle UART and empty queue, a byte pushed at edge N SHALL produce o_tx_start high in cycle N+3, i.e. one cycle each of IDLE, POP and START.
REQ-032 Bytes SHALL leave in arrival order, with no loss unless o_overflow is set.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 On i_RST=1 at an edge: FSM SHALL be IDLE, queue empty, o_level=0, o_full=0, o_overflow=0, o_tx_start=0, o_tx_data=8'h00, terminator flag clear.
REQ-035 Reset SHALL take priority over all other inputs.
REQ-036 A reset during WAIT_BUSY or WAIT_DONE SHALL abandon that byte without issuing a further o_tx_start.

Structure
REQ-037 Package bridge_pkg SHALL hold the FSM state encoding, the TERM_BYTE default and the WAIT_BUSY timeout constant (16).
REQ-038 The queue SHALL be a sub-module sync_fifo with ports i_CLK, i_RST, push, pop, wdata, rdata, level, full and empty.
REQ-039 sync_fifo SHALL have a registered read path.
REQ-040 Overflow, terminator and FSM logic SHALL stay in i2c_uart_bridge_ctrl.

Verification
REQ-041 Single byte: push 8'h5A with UART idle -> o_tx_start in cycle N+3, o_tx_data=8'h5A; UART busy for 10 cycles -> FSM back in IDLE, o_level=0.
REQ-042 Overflow: hold i_tx_busy=1 and push 9 bytes 8'h01..8'h09 -> o_full=1, o_overflow=1, 8'h09 dropped; release busy -> 8'h01..8'h08 sent in order.
REQ-043 STOP with data: i_rx_valid (8'h33) and i_rx_stop on the same edge -> queue holds 8'h33 then 8'h0A.
REQ-044 Full-queue push/pop: full queue with push and pop on the same edge -> o_level stays 8 and o_overflow stays 0.
REQ-045 Busy timeout: i_tx_busy stuck low after o_tx_start -> o_tx_start re-pulses every 17 cycles with unchanged o_tx_data.
REQ-046 Mid-operation reset: assert i_RST in WAIT_DONE with 3 bytes queued -> next cycle o_level=0, o_tx_start=0, and no further starts.

Source files
------------

// File: rtl/bridge_pkg.sv
`default_nettype none
//==============================================================================
// Module   : bridge_pkg
// Brief    : Shared types and constants for the I2C-to-UART byte bridge.
// Revision : 1.0 - initial release
//==============================================================================
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam logic [7:0] c_term_byte_default = 8'h0A;

    // Cycles WAIT_BUSY tolerates without a busy acknowledge before re-requesting.
    localparam int c_busy_timeout = 16;
    localparam int c_busy_cnt_w   = $clog2(c_busy_timeout);

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
//==============================================================================
// Module   : sync_fifo
// Brief    : Single-clock byte FIFO with registered read data.
// Revision : 1.0 - initial release
//==============================================================================
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] c_full_level = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          w_wr_en, w_rd_en;

    assign full    = (level_q == c_full_level);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = rdata_q;

    // A write into a full queue is legal only when a read frees the slot on the same edge.
    assign w_rd_en = pop & ~empty;
    assign w_wr_en = push & (~full | w_rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({w_wr_en, w_rd_en})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_uart_bridge_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : i2c_uart_bridge_ctrl
// Brief    : Queues received I2C bytes (plus optional STOP terminator) and
//            feeds them to a UART transmitter one at a time.
// Revision : 1.0 - initial release
//==============================================================================
module i2c_uart_bridge_ctrl
    import bridge_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter bit         TERM_EN    = 1'b1,
    parameter logic [7:0] TERM_BYTE  = c_term_byte_default
) (
    input  logic                        i_CLK,
    input  logic                        i_RST,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_valid,
    input  logic                        i_rx_stop,
    input  logic                        i_tx_busy,
    input  logic                        i_clr_ovf,
    output logic                        o_tx_start,
    output logic [7:0]                  o_tx_data,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_full,
    output logic                        o_overflow
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state_q;
    logic                    tx_start_q;
    logic [c_busy_cnt_w-1:0] busy_cnt_q;
    logic                    term_pend_q, term_pend_d;
    logic                    overflow_q, overflow_d;

    logic [7:0]    w_rdata;
    logic [LW-1:0] w_level;
    logic          w_full, w_empty;
    logic          w_pop, w_term_fire, w_push_req, w_push_ok, w_drop;
    logic [7:0]    w_push_data;

    // Live data always wins the write port; the terminator waits for a free edge.
    assign w_term_fire = term_pend_q & ~i_rx_valid;
    assign w_push_req  = i_rx_valid | w_term_fire;
    assign w_push_data = i_rx_valid ? i_rx_data : TERM_BYTE;
    assign w_pop       = (state_q == POP);
    assign w_push_ok   = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & ~w_push_ok;

    always_comb begin
        term_pend_d = 1'b0;
        if (TERM_EN) begin
            term_pend_d = term_pend_q ? ~w_term_fire : i_rx_stop;
        end
        overflow_d = w_drop | (overflow_q & ~i_clr_ovf);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            term_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            term_pend_q <= term_pend_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .push  (w_push_ok),
        .pop   (w_pop),
        .wdata (w_push_data),
        .rdata (w_rdata),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!w_empty && !i_tx_busy) begin
                        state_q <= POP;
                    end
                end
                POP: begin
                    state_q    <= START;
                    tx_start_q <= 1'b1;
                end
                START: begin
                    state_q    <= WAIT_BUSY;
                    busy_cnt_q <= '0;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (busy_cnt_q == c_busy_cnt_w'(c_busy_timeout - 1)) begin
                        state_q    <= START;
                        tx_start_q <= 1'b1;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + c_busy_cnt_w'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = w_rdata;
    assign o_level    = w_level;
    assign o_full     = w_full;
    assign o_overflow = overflow_q;

endmodule
`default_nettype wire
